seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Multi-cycle, parametrised ripple adder that adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks through a registered carry. It generalises the single-bit full-adder cell into a word-level arithmetic unit with a start/busy/done handshake, carry-in, carry-out and signed-overflow flags. Area-constrained datapaths use it where a full-width single-cycle adder is too large or too slow.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits added per clock, 1 ≤ CHUNK ≤ WIDTH; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry into bit 0; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result registers update.
- sum  output  WIDTH  result; held between completions.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement overflow: carry into MSB XOR cout.

## Operation
- FSM states: IDLE, RUN. Counter idx, width clog2(N), 0 to N-1.
- IDLE: start=1 at an edge captures a, b, cin into operand registers, loads the carry register with cin, sets idx=0, enters RUN, busy=1.
- RUN: each cycle adds chunk idx (bits idx*CHUNK +: CHUNK) of A and B plus the carry register. It writes the CHUNK-bit partial sum into a working register and updates the carry register with the chunk carry-out.
- On the edge where idx=N-1, the FSM does the following: copies the working register into sum, sets cout and overflow (the carry into the MSB comes from the final chunk), pulses done=1, clears busy and returns to IDLE.
- Working register is internal. sum/cout/overflow change only on the done edge.
- start while busy=1 is ignored; operands are not re-captured.
- start=1 during the done cycle, which is in IDLE, is accepted. This gives back-to-back operations with no gap.
- CHUNK=WIDTH gives N=1: done in the cycle after start.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, FSM=IDLE, idx=0, carry register=0.
- Latency: start accepted at edge k → busy=1 from edge k → done=1 and result valid after edge k+N, for exactly one cycle.
- Throughput: one operation per N cycles.
- a, b and cin may change freely after the accepting edge.
- rst=1 mid-operation aborts on that edge. There is no done pulse, and the previous sum/cout/overflow are cleared to 0.
- rst and start both high at the same edge: rst wins.

## Configuration
- SEQ_CHUNK_ADDER_SUB_EN defined: adds input port sub (1 bit), captured with the operands. When sub=1 the block computes A + ~B + 1, and cin is ignored. cout=1 means no borrow; overflow uses the same signed rule. When sub=0, behaviour is identical to the build without the macro.
- Not defined: no sub port, add-only. Gate count is reduced by the B inverters and the cin mux.

## Test plan
- WIDTH=8, CHUNK=2, a=0xFF, b=0x01, cin=0, start pulse → done exactly 4 cycles later with sum=0x00, cout=1, overflow=0; busy high for those 4 cycles.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, overflow=1; then a=0x80, b=0x80 → sum=0x00, cout=1, overflow=1.
- a=0x12, b=0x34, cin=1, plus a second start with a=0xFF during busy → single done with sum=0x47; the second start is ignored.
- Start, then rst=1 at the 2nd RUN cycle → busy=0, done never pulses, sum=0; a new start afterwards completes normally.
- Back-to-back: start held high across the done cycle with a=0x01, b=0x01 → second done 4 cycles after the first, sum=0x02.
- Built with SEQ_CHUNK_ADDER_SUB_EN: sub=1, a=0x05, b=0x07, cin=1 → sum=0xFE, cout=0, overflow=0; sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder, CHUNK bits per clock; SEQ_CHUNK_ADDER_SUB_EN adds a subtract port
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [WIDTH-1:0] a_sh, b_sh, b_sel;
  logic [CHUNK:0]   part;
  logic             c_sel, last;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  assign b_sel = sub ? ~b : b;
  assign c_sel = sub | cin;
`else
  assign b_sel = b;
  assign c_sel = cin;
`endif
  assign busy     = state_q == RUN;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  // capture on start, then add one chunk per RUN cycle and publish the result on the last one
  always_comb begin
    a_sh    = a_q >> (CHUNK * int'(idx_q));
    b_sh    = b_q >> (CHUNK * int'(idx_q));
    part    = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
    last    = idx_q == IW'(N - 1);
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        idx_d   = '0;
        a_d     = a;
        b_d     = b_sel;
        carry_d = c_sel;
      end
    end else begin
      work_d[CHUNK * int'(idx_q) +: CHUNK] = part[CHUNK-1:0];
      carry_d = part[CHUNK];
      idx_d   = idx_q + 1'b1;
      if (last) begin
        state_d = IDLE;
        idx_d   = '0;
        sum_d   = work_d;
        cout_d  = part[CHUNK];
        ovf_d   = part[CHUNK] ^ (a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ part[CHUNK-1]);
        done_d  = 1'b1;
      end
    end
  end
  // state and datapath registers; reset aborts any operation and clears the published result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed vector bench for seq_chunk_adder at WIDTH=8, CHUNK=2
module tb_seq_chunk_adder;
  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [10];
  seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
  endtask
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input logic [W-1:0] es,
                        input logic eco, input logic eov);
    int cyc;
    bit bok;
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    sub = sv;
`endif
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd1);
    wait_done(cyc, bok);
    check({name, " latency"}, cyc, N);
    check({name, " busy_held"}, 32'(bok), 32'd1);
    check({name, " sum"}, 32'(sum), 32'(es));
    check({name, " cout"}, 32'(cout), 32'(eco));
    check({name, " ovf"}, 32'(overflow), 32'(eov));
    @(negedge clk);
    check({name, " done_pulse"}, 32'(done), 32'd0);
    if (sv) a = '0;
  endtask
  initial begin
    int cyc, pulses;
    bit bok;
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{8'hC0, 8'h80, 1'b0, 8'h40, 1'b1, 1'b1};
    vecs[9] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
             vecs[i].s, vecs[i].co, vecs[i].ov);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bok);
    check("ignore latency", cyc, N - 1);
    check("ignore sum", 32'(sum), 32'h47);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ignore extra_done", pulses, 0);
    run_op("pre_rst", 8'hC0, 8'h80, 1'b0, 1'b0, 8'h40, 1'b1, 1'b1);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    check("abort ovf", 32'(overflow), 32'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no_done", pulses, 0);
    run_op("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done(cyc, bok);
    check("b2b first latency", cyc, N);
    check("b2b first sum", 32'(sum), 32'h07);
    a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted", 32'(busy), 32'd1);
    wait_done(cyc, bok);
    check("b2b second latency", cyc, N);
    check("b2b second sum", 32'(sum), 32'h02);
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    run_op("sub1", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("sub0", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
